// File: rtl/uart_rx_unit_pkg.sv
// Shared definitions for the UART receiver.
//   - Default line/clock parameters.
//   - One-hot receiver state encoding.
//   - Helper to derive the clocks-per-tick divider.
package uart_rx_unit_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 19200;
  localparam int unsigned DEF_N_TICK    = 16;
  localparam int unsigned DEF_N_BITS    = 8;

  // One-hot encoding; o_busy is simply "not RX_IDLE".
  typedef enum logic [4:0] {
    RX_IDLE      = 5'b00001,
    RX_START     = 5'b00010,
    RX_DATA      = 5'b00100,
    RX_STOP      = 5'b01000,
    RX_WAIT_IDLE = 5'b10000
  } rx_state_e;

  // Integer floor of clk/(baud*ticks), clamped so the divider never stalls.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate,
                                                input int unsigned n_tick);
    int unsigned div;
    div = clk_freq / (baud_rate * n_tick);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_unit_baud_rate_gen.sv
// Free-running baud tick divider.
//   i_clock  : system clock
//   i_reset  : asynchronous active-low reset
//   o_tick   : one-cycle pulse every BAUD_DIV clocks
module uart_rx_unit_baud_rate_gen #(
  parameter int unsigned BAUD_DIV = 4,
  parameter int unsigned NB_DIV   = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [NB_DIV-1:0] DIV_LAST = NB_DIV'(BAUD_DIV - 1);

  logic [NB_DIV-1:0] r_cnt;
  logic              r_tick;
  logic              w_wrap;

  assign w_wrap = (r_cnt == DIV_LAST);

  // Tick is registered so it is guaranteed low while in reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with 16x oversampling, feeding the debug unit.
//   i_clock     : system clock
//   i_reset     : asynchronous active-low reset
//   i_rx        : serial line, idle high, asynchronous
//   o_rx_data   : last good byte, held until the next good frame
//   o_rx_done   : one-cycle strobe, o_rx_data valid in the same cycle
//   o_frame_err : one-cycle strobe, stop bit sampled low
//   o_busy      : high whenever the receiver is not idle
//   o_tick      : baud tick, shared with the transmitter
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int unsigned N_BITS    = DEF_N_BITS,
  parameter int unsigned N_TICK    = DEF_N_TICK,
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE,
  parameter int unsigned BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD_RATE, N_TICK),
  parameter int unsigned NB_DIV    = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx,
  output logic [N_BITS-1:0] o_rx_data,
  output logic              o_rx_done,
  output logic              o_frame_err,
  output logic              o_busy,
  output logic              o_tick
);

  localparam int unsigned TICK_W = $clog2(N_TICK);
  localparam int unsigned BIT_W  = $clog2(N_BITS);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(N_TICK / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(N_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_BITS - 1);

  // Tick generator
  logic w_tick;

  uart_rx_unit_baud_rate_gen #(
    .BAUD_DIV (BAUD_DIV),
    .NB_DIV   (NB_DIV)
  ) u_baud_rate_gen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  // Two-flop synchroniser; flops reset to the idle line level.
  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rx_s;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx_s = r_rx_sync;

  // Receiver state
  rx_state_e         r_state,    w_state_next;
  logic [TICK_W-1:0] r_tick_cnt, w_tick_cnt_next;
  logic [BIT_W-1:0]  r_bit_cnt,  w_bit_cnt_next;
  logic [N_BITS-1:0] r_shift,    w_shift_next;
  logic [N_BITS-1:0] r_data,     w_data_next;
  logic              r_done,     w_done_next;
  logic              r_ferr,     w_ferr_next;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= RX_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_data     <= w_data_next;
      r_done     <= w_done_next;
      r_ferr     <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_data_next     = r_data;
    w_done_next     = 1'b0;
    w_ferr_next     = 1'b0;

    unique case (r_state)
      RX_IDLE: begin
        // Start detection runs every clock, not just on ticks.
        if (!w_rx_s) begin
          w_state_next    = RX_START;
          w_tick_cnt_next = '0;
        end
      end

      RX_START: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_HALF) begin
            // Mid start bit: still low means a real frame, else a glitch.
            if (!w_rx_s) begin
              w_state_next    = RX_DATA;
              w_tick_cnt_next = '0;
              w_bit_cnt_next  = '0;
            end else begin
              w_state_next = RX_IDLE;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            // LSB arrives first, so shift in at the top and move right.
            w_shift_next    = {w_rx_s, r_shift[N_BITS-1:1]};
            w_tick_cnt_next = '0;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_next = RX_STOP;
            end else begin
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_tick_cnt_next = '0;
            if (w_rx_s) begin
              w_data_next  = r_shift;
              w_done_next  = 1'b1;
              w_state_next = RX_IDLE;
            end else begin
              w_ferr_next  = 1'b1;
              w_state_next = RX_WAIT_IDLE;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end

      RX_WAIT_IDLE: begin
        // Hold off until the line returns high so a break is not seen as a new start.
        if (w_rx_s) begin
          w_state_next = RX_IDLE;
        end
      end

      default: begin
        w_state_next = RX_IDLE;
      end
    endcase
  end

  assign o_rx_data   = r_data;
  assign o_rx_done   = r_done;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != RX_IDLE);
  assign o_tick      = w_tick;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit at 4 clocks/tick, 64 clocks/bit.
module tb_uart_rx_unit;

  localparam int unsigned CLK_FREQ  = 6_400_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned BIT_CLKS  = 64;
  localparam int unsigned TICK_GAP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;
  logic       tick;

  always #5 clk = ~clk;

  uart_rx_unit #(
    .N_BITS    (8),
    .N_TICK    (16),
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .NB_DIV    (16)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_rx        (rx),
    .o_rx_data   (rx_data),
    .o_rx_done   (rx_done),
    .o_frame_err (frame_err),
    .o_busy      (busy),
    .o_tick      (tick)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
  } row_t;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   since_tick = 0;
  bit   seen_tick = 0;
  int   ticks_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pops and tick period tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen_tick  = 0;
      since_tick = 0;
    end else begin
      since_tick++;
      if (tick) begin
        if (seen_tick) check("tick_period", since_tick, TICK_GAP);
        seen_tick  = 1;
        since_tick = 0;
        if (busy) ticks_busy++;
      end
      if (rx_done || frame_err) begin
        check("done_err_exclusive", {31'd0, rx_done & frame_err}, 0);
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: got done=%0b err=%0b expected none",
                   rx_done, frame_err);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drain", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, rx_data}, 0);
    check({tag, "_done"}, {31'd0, rx_done}, 0);
    check({tag, "_err"},  {31'd0, frame_err}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_tick"}, {31'd0, tick}, 0);
  endtask

  row_t rows[6];

  initial begin
    // {data, stop, idle bits after, expect error, expected o_rx_data at strobe}
    rows[0] = '{8'hA5, 1'b1, 2, 1'b0, 8'hA5};
    rows[1] = '{8'h01, 1'b1, 0, 1'b0, 8'h01};
    rows[2] = '{8'h07, 1'b1, 0, 1'b0, 8'h07};
    rows[3] = '{8'hFF, 1'b1, 2, 1'b0, 8'hFF};
    rows[4] = '{8'h3C, 1'b0, 2, 1'b1, 8'hFF};
    rows[5] = '{8'h55, 1'b1, 2, 1'b0, 8'h55};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_bits(2);

    for (int r = 0; r < 6; r++) begin
      q.push_back('{rows[r].exp_err, rows[r].exp_data});
      send_frame(rows[r].data, rows[r].stop);
      // Framing error case: line stays low for three bit times in total.
      if (!rows[r].stop) begin
        drive_bit(1'b0);
        drive_bit(1'b0);
      end
      if (rows[r].gap > 0) begin
        idle_bits(rows[r].gap);
        wait_drain(200);
        check("idle_after_row", {31'd0, busy}, 0);
        check("data_after_row", {24'd0, rx_data}, {24'd0, rows[r].exp_data});
      end
    end

    // Glitch: 20 clocks low must not start a frame.
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_busy_seen", {31'd0, busy}, 1);
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_back_idle", {31'd0, busy}, 0);
    check("glitch_data_kept", {24'd0, rx_data}, 32'h55);
    idle_bits(1);

    // Reset during data bit 4 of 0xC3, then a clean 0x12.
    begin
      logic [7:0] d;
      d = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx = d[4];
      repeat (BIT_CLKS / 2) @(posedge clk);
      #1;
      check("midframe_busy", {31'd0, busy}, 1);
      rst_n = 1'b0;
      rx    = 1'b1;
      #2;
      check_reset_outputs("midreset_async");
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      idle_bits(2);
      q.push_back('{1'b0, 8'h12});
      send_frame(8'h12, 1'b1);
      idle_bits(2);
      wait_drain(200);
      check("post_reset_data", {24'd0, rx_data}, 32'h12);
    end

    check("ticks_while_busy", {31'd0, (ticks_busy > 0)}, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- UART receiver that directly feeds the debug unit's command/program byte inputs (rx_done / rx_data).
- Deserialises 8N1 frames from the host serial line using 16x oversampling.
- Contains its own baud tick generator and a 2-FF input synchroniser.
- Emits each received byte with a one-cycle done strobe and flags framing errors; sits between the board RX pin and the debug unit.

Parameters:
- N_BITS, 8, data bits per frame (LSB first)
- N_TICK, 16, oversampling ticks per bit
- CLK_FREQ, 50_000_000, i_clock frequency in Hz
- BAUD_RATE, 19200, line rate
- BAUD_DIV, CLK_FREQ/(BAUD_RATE*N_TICK), clocks per tick (integer floor, must be >= 1)
- NB_DIV, 16, width of the tick divider counter (must hold BAUD_DIV-1)

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_rx  in  1  serial line from pin, idle high, asynchronous to i_clock
- o_rx_data  out  N_BITS  last good byte, held until the next good frame
- o_rx_done  out  1  one-cycle strobe, o_rx_data valid in the same cycle
- o_frame_err  out  1  one-cycle strobe, stop bit sampled low
- o_busy  out  1  high whenever state != IDLE
- o_tick  out  1  baud tick, exported for uart_tx reuse

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; all counters 0; synchroniser flops=1.
  - o_rx_data=0, o_rx_done=0, o_frame_err=0, o_busy=0, o_tick=0.
- Synchroniser: i_rx passes through two flops to give rx_s. All FSM decisions use rx_s only (2-cycle input latency).
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1; o_tick=1 for one cycle when the count equals BAUD_DIV-1, then the counter wraps to 0.
  - It is never reset by the FSM.
- FSM, one-hot, 5 states: IDLE, START, DATA, STOP, WAIT_IDLE. tick_cnt is 4 bits, bit_cnt is 3 bits.
  - IDLE: on rx_s=0 -> START, tick_cnt=0. Detection is per clock, not per tick.
  - START: on each tick, tick_cnt++. When tick_cnt==N_TICK/2-1 on a tick:
    - if rx_s=0 -> DATA, with tick_cnt=0 and bit_cnt=0;
    - else -> IDLE (glitch rejected, no strobe).
  - DATA: on each tick, tick_cnt++. When tick_cnt==N_TICK-1 on a tick:
    - shift rx_s into the shift-reg MSB (right shift, so LSB is received first);
    - tick_cnt=0;
    - if bit_cnt==N_BITS-1 -> STOP, else bit_cnt++.
  - STOP: when tick_cnt==N_TICK-1 on a tick, sample rx_s:
    - rx_s=1 -> o_rx_data<=shift-reg, o_rx_done=1 for the next clock, -> IDLE;
    - rx_s=0 -> o_frame_err=1 for the next clock, o_rx_data unchanged, -> WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then -> IDLE. This prevents a break condition from retriggering START.
- Latency: o_rx_done rises about 9.5 bit periods plus 3 clocks after the start-bit falling edge on i_rx.
- o_rx_done and o_frame_err are registered and never high together. Each is exactly one i_clock wide regardless of BAUD_DIV.
- A new falling edge is accepted from IDLE in the clock immediately after the done strobe (back-to-back frames).
- Reset mid-frame: immediate return to IDLE, and the partial byte is discarded. If reset releases while the line is low, a frame is started on the first synchronised low.
- Ticks are ignored outside START/DATA/STOP.

Decomposition:
- Shared parameters header: state encodings (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE, 5-bit one-hot), default CLK_FREQ/BAUD_RATE/N_TICK.
- Natural sub-module: baud_rate_gen (tick divider). It is instantiated here and shared with uart_tx through o_tick.

Test Plan (override CLK_FREQ=6_400_000, BAUD_RATE=100_000 -> BAUD_DIV=4, 64 clocks/bit):
- Single frame 0xA5, stop=1 -> one o_rx_done pulse; o_rx_data=0xA5; o_frame_err=0; o_busy low afterwards.
- Back-to-back frames 0x01, 0x07, 0xFF with no idle gap -> three done pulses with data 0x01, 0x07, 0xFF; no errors.
- Glitch: i_rx low for 20 clocks, then high -> no done, no error, state back to IDLE before 40 clocks; o_rx_data keeps its previous value.
- Framing error: frame 0x3C with stop bit=0, line held low for 3 bit times, then high -> exactly one o_frame_err pulse; no done; o_rx_data unchanged; next valid frame 0x55 received correctly.
- Reset mid-frame: assert i_reset=0 during data bit 4 of 0xC3, release, then send 0x12 -> only 0x12 strobed; all outputs 0 during reset.
- Tick check: o_tick period is exactly 4 clocks, one cycle wide, and continues through all states.
